// File: rtl/fadd_pkg.sv
// Shared width limit, word type and a golden {cout,sum} function for full_adder.
package fadd_pkg;

  localparam int FADD_MAX_WIDTH = 64;

  typedef logic [FADD_MAX_WIDTH-1:0] fadd_word_t;

  // Result layout: bits [width-1:0] are the sum, bit [width] is the carry-out.
  function automatic logic [FADD_MAX_WIDTH:0] fadd_ref(input fadd_word_t a,
                                                       input fadd_word_t b,
                                                       input logic cin,
                                                       input int unsigned width);
    logic [FADD_MAX_WIDTH:0] mask;
    logic [FADD_MAX_WIDTH:0] total;
    mask  = ({{FADD_MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
    total = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{FADD_MAX_WIDTH{1'b0}}, cin};
    return total;
  endfunction

endpackage

// File: rtl/fadd_cell.sv
// Combinational 1-bit full adder leaf cell; zero latency, no flow control.
module fadd_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder, 1-cycle latency, no backpressure (one result per valid cycle).
// Optional signed-overflow output ovf when FADD_OVF_EN is defined.
module full_adder
  import fadd_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam bit WIDTH_OK = (WIDTH >= 1) && (WIDTH <= FADD_MAX_WIDTH);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fadd_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             vld_q, vld_d;
`ifdef FADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Enable-gated capture keeps X on idle operands out of the result registers.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = in_valid && WIDTH_OK;
`ifdef FADD_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (in_valid) begin
      sum_d  = sum_c;
      cout_d = carry[WIDTH];
`ifdef FADD_OVF_EN
      ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
`ifdef FADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
`ifdef FADD_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;
`ifdef FADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1, 4 and 8 (ovf checked when FADD_OVF_EN is defined).
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1, ov1, s1, co1;
  logic       v4, c4, ov4, co4;
  logic [3:0] a4, b4, s4;
  logic       v8, c8, ov8, co8;
  logic [7:0] a8, b8, s8;
`ifdef FADD_OVF_EN
  logic       of1, of4, of8;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FADD_OVF_EN
    , .ovf(of1)
`endif
  );

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4), .sum(s4), .cout(co4)
`ifdef FADD_OVF_EN
    , .ovf(of4)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef FADD_OVF_EN
    , .ovf(of8)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned integer sum, split into {cout,sum}.
  function automatic int ref_total(input int a, input int b, input int cin);
    return a + b + cin;
  endfunction

  // Reference: operands read as two's complement; overflow if the true signed result is unrepresentable.
  function automatic bit ref_ovf(input int a, input int b, input int cin, input int w);
    int sa, sb, r;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa + sb + cin;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  typedef struct {
    logic       a, b, cin;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int exp_sum8, exp_cout8, exp_ovf8, tot;
    bit vld;
    int ra, rb, rc;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    // Reset held with valid all-ones inputs: every output stays cleared.
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_w1", {13'd0, ov1, co1, s1}, 16'h0);
      chk("rst_w4", {10'd0, ov4, co4, s4}, 16'h0);
      chk("rst_w8", {6'd0, ov8, co8, s8}, 16'h0);
`ifdef FADD_OVF_EN
      chk("rst_ovf", {13'd0, of1, of4, of8}, 16'h0);
`endif
    end
    rst_n = 1'b1;
    v4 = 1'b0; v8 = 1'b0;

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].cin;
      step();
      chk($sformatf("tt%0d_sum", i), {14'd0, co1, s1}, {14'd0, tbl[i].exp});
      chk($sformatf("tt%0d_vld", i), {15'd0, ov1}, 16'h1);
`ifdef FADD_OVF_EN
      chk($sformatf("tt%0d_ovf", i), {15'd0, of1},
          {15'd0, ref_ovf(int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].cin), 1)});
`endif
    end

    // Hold: last result 11 must survive three idle cycles.
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_sum", {14'd0, co1, s1}, 16'h3);
      chk("hold_vld", {15'd0, ov1}, 16'h0);
    end

    // Mid-stream reset.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    step();
    chk("pre_rst", {13'd0, ov1, co1, s1}, 16'h6);
    rst_n = 1'b0;
    step();
    chk("mid_rst", {13'd0, ov1, co1, s1}, 16'h0);
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    step();
    chk("post_rst", {13'd0, ov1, co1, s1}, 16'h5);
    v1 = 1'b0;

    // WIDTH=4 carry ripple.
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    step();
    chk("w4_ripple", {11'd0, ov4, co4, s4}, 16'h30);
`ifdef FADD_OVF_EN
    chk("w4_ripple_ovf", {15'd0, of4}, 16'h0);
`endif
    a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
    step();
    chk("w4_signed", {11'd0, ov4, co4, s4}, 16'h28);
`ifdef FADD_OVF_EN
    chk("w4_signed_ovf", {15'd0, of4}, 16'h1);
`endif
    v4 = 1'b0;

    // WIDTH=8 random against the reference model.
    exp_sum8 = 0; exp_cout8 = 0; exp_ovf8 = 0;
    for (int i = 0; i < 1000; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      ra = (i == 0) ? 255 : int'($urandom_range(0, 255));
      rb = (i == 0) ? 255 : int'($urandom_range(0, 255));
      rc = (i == 0) ? 1 : int'($urandom_range(0, 1));
      if (i == 0) vld = 1'b1;
      v8 = vld; a8 = ra[7:0]; b8 = rb[7:0]; c8 = rc[0];
      if (vld) begin
        tot = ref_total(ra, rb, rc);
        exp_sum8  = tot % 256;
        exp_cout8 = tot / 256;
        exp_ovf8  = int'(ref_ovf(ra, rb, rc, 8));
      end
      step();
      chk("w8_sum", {8'd0, s8}, exp_sum8[15:0]);
      chk("w8_cout", {15'd0, co8}, exp_cout8[15:0]);
      chk("w8_vld", {15'd0, ov8}, {15'd0, vld});
`ifdef FADD_OVF_EN
      chk("w8_ovf", {15'd0, of8}, exp_ovf8[15:0]);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
